// File: rtl/branch_pred.sv
// Direct-mapped branch predictor with tagged saturating counters and branch targets,
// plus a branch resolution unit that handles compare, redirect, table update and statistics.
module branch_pred #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 16,
    parameter int CNT_W   = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic [XLEN-1:0] pc_f,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            res_valid,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [XLEN-1:0] pc_e,
    input  logic [XLEN-1:0] imm_e,
    input  logic            pred_taken_e,
    input  logic [XLEN-1:0] pred_target_e,
    output logic            br_taken,
    output logic            mispredict,
    output logic            illegal,
    output logic [XLEN-1:0] redirect_pc,
    output logic [31:0]     n_branch,
    output logic [31:0]     n_mispred
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_WEAK_T = CNT_ONE << (CNT_W - 1);
    localparam logic [CNT_W-1:0] CNT_WEAK_N = CNT_WEAK_T - CNT_ONE;

    logic                  valid_rd [ENTRIES];
    logic [TAG_W-1:0]      tag_rd   [ENTRIES];
    logic [CNT_W-1:0]      cnt_rd   [ENTRIES];
    logic [XLEN-1:0]       tgt_rd   [ENTRIES];

    logic [IDX_W-1:0] idx_f, idx_e;
    logic [TAG_W-1:0] tag_f, tag_e;
    logic             cond, legal, upd_en;
    logic [XLEN-1:0]  target;
    logic             unused_pc_bits;

    assign idx_f = pc_f[IDX_W+1:2];
    assign tag_f = pc_f[XLEN-1:IDX_W+2];
    assign idx_e = pc_e[IDX_W+1:2];
    assign tag_e = pc_e[XLEN-1:IDX_W+2];
    assign unused_pc_bits = ^{pc_f[1:0], pc_e[1:0]};

    // Lookup reads only registered state, so a same-cycle update is seen next cycle.
    assign pred_taken  = valid_rd[idx_f] && (tag_rd[idx_f] == tag_f) && cnt_rd[idx_f][CNT_W-1];
    assign pred_target = tgt_rd[idx_f];

    always_comb begin
        cond  = 1'b0;
        legal = 1'b1;
        case (funct3)
            3'b000:  cond = (a == b);
            3'b001:  cond = (a != b);
            3'b100:  cond = ($signed(a) < $signed(b));
            3'b101:  cond = !($signed(a) < $signed(b));
            3'b110:  cond = (a < b);
            3'b111:  cond = (a >= b);
            default: legal = 1'b0;
        endcase
    end

    assign upd_en      = res_valid && legal;
    assign target      = pc_e + imm_e;
    assign br_taken    = upd_en && cond;
    assign illegal     = res_valid && !legal;
    assign redirect_pc = br_taken ? target : pc_e + XLEN'(4);
    assign mispredict  = upd_en &&
                         ((br_taken != pred_taken_e) || (br_taken && (pred_target_e != target)));

    genvar gi;
    generate
        for (gi = 0; gi < ENTRIES; gi++) begin : g_entry
            logic             valid_q, valid_d;
            logic [TAG_W-1:0] tag_q, tag_d;
            logic [CNT_W-1:0] cnt_q, cnt_d;
            logic [XLEN-1:0]  tgt_q, tgt_d;
            logic             sel, hit;

            assign sel = upd_en && (idx_e == IDX_W'(gi));
            assign hit = valid_q && (tag_q == tag_e);

            always_comb begin
                valid_d = valid_q;
                tag_d   = tag_q;
                cnt_d   = cnt_q;
                tgt_d   = tgt_q;
                if (flush) begin
                    valid_d = 1'b0;
                end else if (sel) begin
                    if (hit) begin
                        if (br_taken) begin
                            if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_ONE;
                            tgt_d = target;
                        end else if (cnt_q != '0) begin
                            cnt_d = cnt_q - CNT_ONE;
                        end
                    end else if (br_taken) begin
                        valid_d = 1'b1;
                        tag_d   = tag_e;
                        tgt_d   = target;
                        cnt_d   = CNT_WEAK_T;
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_q <= 1'b0;
                    tag_q   <= '0;
                    cnt_q   <= CNT_WEAK_N;
                    tgt_q   <= '0;
                end else begin
                    valid_q <= valid_d;
                    tag_q   <= tag_d;
                    cnt_q   <= cnt_d;
                    tgt_q   <= tgt_d;
                end
            end

            assign valid_rd[gi] = valid_q;
            assign tag_rd[gi]   = tag_q;
            assign cnt_rd[gi]   = cnt_q;
            assign tgt_rd[gi]   = tgt_q;
        end
    endgenerate

    // Statistics keep counting through flush; only reset clears them.
    logic [31:0] n_branch_q, n_branch_d, n_mispred_q, n_mispred_d;

    always_comb begin
        n_branch_d  = n_branch_q;
        n_mispred_d = n_mispred_q;
        if (upd_en && (n_branch_q != '1)) n_branch_d = n_branch_q + 32'd1;
        if (mispredict && (n_mispred_q != '1)) n_mispred_d = n_mispred_q + 32'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            n_branch_q  <= '0;
            n_mispred_q <= '0;
        end else begin
            n_branch_q  <= n_branch_d;
            n_mispred_q <= n_mispred_d;
        end
    end

    assign n_branch  = n_branch_q;
    assign n_mispred = n_mispred_q;
endmodule

// File: doc/branch_pred.md
BRANCH_PRED -- requirements
Module: branch_pred

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning datapath/address width.
REQ-002 SHALL have parameter ENTRIES, default 16, meaning predictor table depth; power of two, >= 2; IDX_W = log2(ENTRIES).
REQ-003 SHALL have parameter CNT_W, default 2, meaning saturating-counter width; >= 1.
REQ-004 SHALL have port clk  in  1  clock; single clock domain, all state updates on rising edge.
REQ-005 SHALL have port rst  in  1  reset; synchronous, active-high.
REQ-006 SHALL have port flush  in  1  invalidate all table entries.
REQ-007 SHALL have port pc_f  in  XLEN  fetch-stage PC to predict.
REQ-008 SHALL have port pred_taken  out  1  predicted taken for pc_f.
REQ-009 SHALL have port pred_target  out  XLEN  predicted target for pc_f; valid only when pred_taken=1.
REQ-010 SHALL have port res_valid  in  1  a branch resolves this cycle.
REQ-011 SHALL have port funct3  in  3  branch type (000 beq, 001 bne, 100 blt, 101 bge, 110 bltu, 111 bgeu).
REQ-012 SHALL have ports a, b  in  XLEN  rs1, rs2 operand values.
REQ-013 SHALL have ports pc_e, imm_e  in  XLEN  resolving branch PC and B-immediate (sign-extended).
REQ-014 SHALL have ports pred_taken_e, pred_target_e  in  1, XLEN  prediction carried with the branch.
REQ-015 SHALL have ports br_taken, mispredict, illegal  out  1 each  resolution results.
REQ-016 SHALL have port redirect_pc  out  XLEN  correct next PC for the resolving branch.
REQ-017 SHALL have ports n_branch, n_mispred  out  32 each  statistics counters.

Function
REQ-018 Index SHALL be pc[IDX_W+1:2]; tag SHALL be pc[XLEN-1:IDX_W+2]; each entry holds valid, tag, CNT_W-bit counter, XLEN target.
REQ-019 Lookup SHALL be combinational from registered table state: hit = valid && tag match; pred_taken = hit && counter MSB; pred_target = entry target.
REQ-020 Compare SHALL be combinational: beq a==b; bne a!=b; blt/bge signed a<b / not; bltu/bgeu unsigned a<b / not; blt/bge SHALL be correct where a-b overflows (e.g. a=0x80000000, b=2 -> a<b).
REQ-021 funct3 010/011 with res_valid=1 SHALL give illegal=1, br_taken=0, mispredict=0, no table or counter update.
REQ-022 br_taken, mispredict, illegal SHALL be 0 when res_valid=0.
REQ-023 target = pc_e+imm_e modulo 2^XLEN; redirect_pc = br_taken ? target : pc_e+4 (wraps modulo 2^XLEN).
REQ-024 mispredict = res_valid && legal && (br_taken != pred_taken_e || (br_taken && pred_target_e != target)).
REQ-025 Update on legal resolve, entry hit by pc_e: counter +1 if taken (saturate at 2^CNT_W-1), -1 if not (saturate at 0); target overwritten when taken.
REQ-026 Update on legal resolve, miss, taken: allocate (replace) entry: valid=1, tag, target, counter=2^(CNT_W-1) (weakly taken).
REQ-027 Miss, not taken: no allocation.
REQ-028 Same-cycle lookup and update of same index: lookup SHALL see pre-update contents; update visible next cycle.
REQ-029 n_branch SHALL increment per legal resolve; n_mispred per mispredict; both saturate at 0xFFFFFFFF.
REQ-030 flush SHALL clear all valid bits at the edge; a same-cycle update SHALL be discarded; stats unaffected.

Reset
REQ-031 rst SHALL, at the edge, clear all valid bits, set all counters to 2^(CNT_W-1)-1, clear n_branch and n_mispred; rst SHALL take priority over flush and updates.
REQ-032 After reset, pred_taken=0 for every pc_f; combinational outputs SHALL depend only on current inputs and state.
REQ-033 rst asserted mid-sequence SHALL discard the in-flight update of that cycle.

Verification
REQ-034 rst; pc_f=0x100 -> pred_taken=0; n_branch=0, n_mispred=0.
REQ-035 Resolve blt a=0x80000000 b=2, pc_e=0x100, imm_e=0x20, pred_taken_e=0 -> br_taken=1, mispredict=1, redirect_pc=0x120; next cycle pc_f=0x100 -> pred_taken=1, pred_target=0x120, n_mispred=1.
REQ-036 Same branch not taken twice (bge a=5 b=2... replaced by bltu a=5 b=2 at 0x100) -> counter 2->1->0; pred_taken=0 after first; two further not-taken resolves leave counter at 0.
REQ-037 bgeu a=0xFFFFFFFF b=0 -> taken; bge same operands -> not taken; funct3=010 -> illegal=1, n_branch unchanged.
REQ-038 pc_e=0x100 then pc_e=0x100+4*ENTRIES (same index, different tag), both taken -> second replaces first; pc_f=0x100 misses.
REQ-039 Allocate entry, then flush with simultaneous taken resolve at another PC -> all lookups miss next cycle; stats still count that resolve.
